// File: rtl/csr_arbiter.sv
// csr_arbiter: shares one CSR bus between several masters, one access per grant
// (arbitrate, bus cycle, acknowledge), with locked sequences and an idle release timeout.
module csr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int ROUND_ROBIN = 1,
    parameter int LOCK_TMO    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_a,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             csr_a,
    output logic                          csr_we,
    output logic [DATA_W-1:0]             csr_do,
    input  logic [DATA_W-1:0]             csr_di,
    output logic                          busy
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [7:0]             lock_cnt_q, lock_cnt_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic [ADDR_W-1:0]      a_q, a_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      do_q, do_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       next_rr;

    // First requester found when scanning upward from start, wrapping at NUM_MASTERS.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [IDX_W-1:0]       start);
        logic [IDX_W-1:0]       win;
        logic [NUM_MASTERS-1:0] rot;
        int                     idx;
        win = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_MASTERS;
            rot = req >> idx;
            if (rot[0]) win = IDX_W'(idx);
        end
        return win;
    endfunction

    always_comb begin
        win_idx = pick_winner(m_req, (ROUND_ROBIN != 0) ? rr_q : '0);
        next_rr = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        a_d        = a_q;
        we_d       = 1'b0;
        do_d       = do_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    owner_d = win_idx;
                    gnt_d   = NUM_MASTERS'(1) << win_idx;
                    a_d     = m_a[win_idx*ADDR_W +: ADDR_W];
                    we_d    = m_we[win_idx];
                    do_d    = m_wdata[win_idx*DATA_W +: DATA_W];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d = csr_di;
                ack_d   = NUM_MASTERS'(1) << owner_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (m_lock[owner_q]) begin
                    lock_cnt_d = '0;
                    state_d    = ST_LOCKED;
                end else begin
                    gnt_d   = '0;
                    rr_d    = next_rr;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Only the owner may continue; idle cycles count toward the forced release.
                if (m_req[owner_q]) begin
                    a_d     = m_a[owner_q*ADDR_W +: ADDR_W];
                    we_d    = m_we[owner_q];
                    do_d    = m_wdata[owner_q*DATA_W +: DATA_W];
                    state_d = ST_ACCESS;
                end else if (!m_lock[owner_q] || (lock_cnt_q == 8'(LOCK_TMO - 1))) begin
                    gnt_d   = '0;
                    rr_d    = next_rr;
                    state_d = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            a_q        <= '0;
            we_q       <= 1'b0;
            do_q       <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            a_q        <= a_d;
            we_q       <= we_d;
            do_q       <= do_d;
            rdata_q    <= rdata_d;
        end
    end

    assign m_gnt   = gnt_q;
    assign m_ack   = ack_q;
    assign m_rdata = rdata_q;
    assign csr_a   = a_q;
    assign csr_we  = we_q;
    assign csr_do  = do_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: scenario tasks plus randomized transactions checked against a
// transaction-level model (rotating pointer, cycle budget per access) for csr_arbiter.
module tb_csr_arbiter;
    localparam int N   = 2;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  m_req, m_lock, m_we;
    logic [N*AW-1:0] m_a;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0] csr_di;

    logic [N-1:0]  m_gnt, m_ack, f_gnt, f_ack;
    logic [DW-1:0] m_rdata, f_rdata, csr_do, f_csr_do;
    logic [AW-1:0] csr_a, f_csr_a;
    logic          csr_we, f_csr_we, busy, f_busy;

    int checks = 0;
    int errors = 0;
    int exp_rr = 0;

    always #5 clk = ~clk;

    csr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1), .LOCK_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_lock(m_lock), .m_we(m_we), .m_a(m_a),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack), .m_rdata(m_rdata), .csr_a(csr_a),
        .csr_we(csr_we), .csr_do(csr_do), .csr_di(csr_di), .busy(busy));

    csr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0), .LOCK_TMO(TMO)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_lock(m_lock), .m_we(m_we), .m_a(m_a),
        .m_wdata(m_wdata), .m_gnt(f_gnt), .m_ack(f_ack), .m_rdata(f_rdata), .csr_a(f_csr_a),
        .csr_we(f_csr_we), .csr_do(f_csr_do), .csr_di(csr_di), .busy(f_busy));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++)
            if (req[(start + k) % N]) return (start + k) % N;
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_master(input int i, input logic req, input logic lock, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[i] = req;
        m_lock[i] = lock;
        m_we[i] = we;
        m_a[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle_all;
        m_req  = '0;
        m_lock = '0;
        m_we   = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m_req = '1; m_we = '1; m_a = '1; m_wdata = '1; csr_di = '1;
        tick; tick;
        checks++;
        if ({m_gnt, m_ack, csr_we, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000", {m_gnt, m_ack, csr_we, busy});
        end
        checks++;
        if ({csr_a, csr_do, m_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h want 0", {csr_a, csr_do, m_rdata});
        end
        checks++;
        if ({f_gnt, f_ack, f_csr_we, f_busy, f_csr_a, f_csr_do, f_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_fixed: got %h want 0",
                     {f_gnt, f_ack, f_csr_we, f_busy, f_csr_a, f_csr_do, f_rdata});
        end
        idle_all;
        csr_di = '0;
        rst_n  = 1'b1;
        tick;
        checks++;
        if ({m_gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want 000", {m_gnt, busy});
        end
        exp_rr = 0;
    endtask

    task automatic test_single_write;
        set_master(0, 1'b1, 1'b0, 1'b1, 5'h0c, 8'h80);
        tick;
        checks++;
        if ({m_gnt, m_ack, csr_we, busy, csr_a, csr_do} !== {2'b01, 2'b00, 1'b1, 1'b1, 5'h0c, 8'h80}) begin
            errors++;
            $display("[TB] FAIL write_access: got %h want %h", {m_gnt, m_ack, csr_we, busy, csr_a, csr_do},
                     {2'b01, 2'b00, 1'b1, 1'b1, 5'h0c, 8'h80});
        end
        tick;
        checks++;
        if ({m_gnt, m_ack, csr_we, busy} !== {2'b01, 2'b01, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL write_ack: got %b want 01010 1", {m_gnt, m_ack, csr_we, busy});
        end
        m_req[0] = 1'b0;
        tick;
        checks++;
        if ({m_gnt, m_ack, csr_we, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL write_release: got %b want 000000", {m_gnt, m_ack, csr_we, busy});
        end
        exp_rr = 1;
    endtask

    task automatic test_read;
        set_master(1, 1'b1, 1'b0, 1'b0, 5'h03, 8'h5a);
        tick;
        checks++;
        if ({m_gnt, m_ack, csr_we, busy, csr_a} !== {2'b10, 2'b00, 1'b0, 1'b1, 5'h03}) begin
            errors++;
            $display("[TB] FAIL read_access: got %h want %h", {m_gnt, m_ack, csr_we, busy, csr_a},
                     {2'b10, 2'b00, 1'b0, 1'b1, 5'h03});
        end
        csr_di = 8'h20;
        tick;
        checks++;
        if ({m_ack, csr_we, m_rdata} !== {2'b10, 1'b0, 8'h20}) begin
            errors++;
            $display("[TB] FAIL read_ack: got %h want %h", {m_ack, csr_we, m_rdata}, {2'b10, 1'b0, 8'h20});
        end
        m_req[1] = 1'b0;
        csr_di   = '0;
        tick;
        checks++;
        if ({m_gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL read_release: got %b want 000", {m_gnt, busy});
        end
        exp_rr = 0;
    endtask

    task automatic test_contention;
        int w;
        set_master(0, 1'b1, 1'b0, 1'b1, 5'h01, 8'h11);
        set_master(1, 1'b1, 1'b0, 1'b1, 5'h02, 8'h22);
        for (int g = 0; g < 4; g++) begin
            w = pick(m_req, exp_rr);
            tick;
            checks++;
            if (m_gnt !== onehot(w)) begin
                errors++;
                $display("[TB] FAIL contention_gnt[%0d]: got %b want %b", g, m_gnt, onehot(w));
            end
            checks++;
            if (f_gnt !== 2'b01) begin
                errors++;
                $display("[TB] FAIL fixed_gnt[%0d]: got %b want 01", g, f_gnt);
            end
            tick;
            checks++;
            if ({m_ack, f_ack} !== {onehot(w), 2'b01}) begin
                errors++;
                $display("[TB] FAIL contention_ack[%0d]: got %b want %b", g, {m_ack, f_ack}, {onehot(w), 2'b01});
            end
            if (g == 3) idle_all;
            tick;
            exp_rr = (w + 1) % N;
        end
        checks++;
        if ({m_gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL contention_end: got %b want 000", {m_gnt, busy});
        end
    endtask

    task automatic test_lock;
        set_master(1, 1'b1, 1'b1, 1'b0, 5'h10, 8'h00);
        tick;
        set_master(0, 1'b1, 1'b0, 1'b1, 5'h01, 8'h33);
        for (int r = 0; r < 3; r++) begin
            checks++;
            if ({m_gnt, csr_we, csr_a} !== {2'b10, 1'b0, 5'(5'h10 + r)}) begin
                errors++;
                $display("[TB] FAIL lock_access[%0d]: got %h want %h", r, {m_gnt, csr_we, csr_a},
                         {2'b10, 1'b0, 5'(5'h10 + r)});
            end
            csr_di = 8'(8'ha0 + r);
            tick;
            checks++;
            if ({m_ack, m_rdata} !== {2'b10, 8'(8'ha0 + r)}) begin
                errors++;
                $display("[TB] FAIL lock_ack[%0d]: got %h want %h", r, {m_ack, m_rdata}, {2'b10, 8'(8'ha0 + r)});
            end
            if (r < 2) begin
                m_a[1*AW +: AW] = 5'(5'h10 + r + 1);
                tick;
                checks++;
                if ({m_gnt, m_ack, busy} !== {2'b10, 2'b00, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL lock_hold[%0d]: got %b want 10001", r, {m_gnt, m_ack, busy});
                end
                tick;
            end else begin
                m_req[1]  = 1'b0;
                m_lock[1] = 1'b0;
            end
        end
        tick;
        checks++;
        if ({m_gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL lock_release: got %b want 000", {m_gnt, busy});
        end
        exp_rr = 0;
        tick;
        checks++;
        if (m_gnt !== onehot(pick(m_req, exp_rr))) begin
            errors++;
            $display("[TB] FAIL lock_next_owner: got %b want 01", m_gnt);
        end
        tick;
        m_req[0] = 1'b0;
        tick;
        exp_rr = 1;
    endtask

    task automatic test_lock_timeout;
        set_master(0, 1'b1, 1'b1, 1'b1, 5'h07, 8'h44);
        tick;
        tick;
        m_req[0] = 1'b0;
        set_master(1, 1'b1, 1'b0, 1'b1, 5'h08, 8'h55);
        for (int t = 0; t < TMO; t++) begin
            tick;
            checks++;
            if ({m_gnt, m_ack, csr_we, busy} !== {2'b01, 2'b00, 1'b0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL tmo_hold[%0d]: got %b want 010001", t, {m_gnt, m_ack, csr_we, busy});
            end
        end
        tick;
        checks++;
        if ({m_gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL tmo_release: got %b want 000", {m_gnt, busy});
        end
        m_lock[0] = 1'b0;
        tick;
        checks++;
        if (m_gnt !== onehot(pick(m_req, exp_rr))) begin
            errors++;
            $display("[TB] FAIL tmo_next_owner: got %b want 10", m_gnt);
        end
        tick;
        m_req[1] = 1'b0;
        tick;
        exp_rr = 0;
    endtask

    task automatic test_lock_drop;
        set_master(0, 1'b1, 1'b1, 1'b0, 5'h09, 8'h00);
        tick;
        tick;
        m_req[0] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick;
            checks++;
            if ({m_gnt, busy} !== 3'b011) begin
                errors++;
                $display("[TB] FAIL drop_hold[%0d]: got %b want 011", t, {m_gnt, busy});
            end
        end
        m_lock[0] = 1'b0;
        tick;
        checks++;
        if ({m_gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL drop_release: got %b want 000", {m_gnt, busy});
        end
        exp_rr = 1;
    endtask

    task automatic test_reset_midop;
        set_master(1, 1'b1, 1'b0, 1'b1, 5'h1f, 8'hff);
        tick;
        checks++;
        if ({m_gnt, csr_we} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL midop_access: got %b want 101", {m_gnt, csr_we});
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if ({m_gnt, m_ack, csr_we, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL midop_reset: got %b want 000000", {m_gnt, m_ack, csr_we, busy});
        end
        rst_n = 1'b1;
        idle_all;
        exp_rr = 0;
        for (int t = 0; t < 3; t++) begin
            tick;
            checks++;
            if ({m_ack, csr_we} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL midop_no_ack[%0d]: got %b want 000", t, {m_ack, csr_we});
            end
        end
        set_master(0, 1'b1, 1'b0, 1'b0, 5'h04, 8'h00);
        set_master(1, 1'b1, 1'b0, 1'b0, 5'h05, 8'h00);
        tick;
        checks++;
        if (m_gnt !== onehot(pick(m_req, exp_rr))) begin
            errors++;
            $display("[TB] FAIL midop_rr_cleared: got %b want 01", m_gnt);
        end
        tick;
        idle_all;
        tick;
        exp_rr = 1;
    endtask

    task automatic test_random;
        logic [N-1:0]  mask;
        logic [DW-1:0] di;
        int            w;
        for (int it = 0; it < 24; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_master(i, mask[i], 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
            w = pick(mask, exp_rr);
            tick;
            checks++;
            if ({m_gnt, csr_we, csr_a, csr_do} !== {onehot(w), m_we[w], m_a[w*AW +: AW], m_wdata[w*DW +: DW]}) begin
                errors++;
                $display("[TB] FAIL rand_access[%0d]: got %h want %h", it, {m_gnt, csr_we, csr_a, csr_do},
                         {onehot(w), m_we[w], m_a[w*AW +: AW], m_wdata[w*DW +: DW]});
            end
            di     = DW'($urandom);
            csr_di = di;
            tick;
            checks++;
            if ({m_ack, csr_we} !== {onehot(w), 1'b0}) begin
                errors++;
                $display("[TB] FAIL rand_ack[%0d]: got %b want %b", it, {m_ack, csr_we}, {onehot(w), 1'b0});
            end
            if (!m_we[w]) begin
                checks++;
                if (m_rdata !== di) begin
                    errors++;
                    $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", it, m_rdata, di);
                end
            end
            idle_all;
            tick;
            checks++;
            if ({m_gnt, busy} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL rand_release[%0d]: got %b want 000", it, {m_gnt, busy});
            end
            exp_rr = (w + 1) % N;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        m_req   = '0;
        m_lock  = '0;
        m_we    = '0;
        m_a     = '0;
        m_wdata = '0;
        csr_di  = '0;
        $display("[TB] starting csr_arbiter bench");
        test_reset;
        test_single_write;
        test_read;
        test_contention;
        test_lock;
        test_lock_timeout;
        test_lock_drop;
        test_reset_midop;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
